mitchell_mul_pipe: RTL

MITCHELL_MUL_PIPE -- requirements
Module: mitchell_mul_pipe

---
 rtl/mitchell_mul_pipe.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mitchell_mul_pipe.sv
// mitchell_mul_pipe
// Three-stage pipelined Mitchell logarithmic multiplier (approximate product).
// Operands are turned into magnitude / leading-one position / fraction, the
// logarithms are added, and the antilog is taken by a shift.
//
// Build option: define MITCHELL_ERR_COMP_EN to add a 1/16 correction to the
// fractional sum when both fractions are nonzero. Powers of two stay exact.
//
// Ports
//   clk_i     : clock, rising edge
//   rstn_i    : asynchronous active-low reset
//   x_i, y_i  : operands, WIDTH bits
//   signed_i  : 1 = two's-complement operands, 0 = unsigned
//   valid_i   : operands valid
//   ready_o   : operands accepted when valid_i & ready_o
//   p_o       : approximate product, 2*WIDTH bits
//   valid_o   : p_o valid
//   ready_i   : downstream accepts p_o
module mitchell_mul_pipe #(
    parameter int WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [WIDTH-1:0]     x_i,
    input  logic [WIDTH-1:0]     y_i,
    input  logic                 signed_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   p_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    localparam int KW = $clog2(WIDTH);
    localparam int FW = WIDTH - 1;

    // Two's-complement absolute value; the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic s);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        return (s && sv[WIDTH-1]) ? WIDTH'(-sv) : v;
    endfunction

    function automatic logic [KW-1:0] lead_one(input logic [WIDTH-1:0] v);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < WIDTH; i++)
            if (v[i]) k = KW'(i);
        return k;
    endfunction

    // Shift the leading one up to the MSB and keep the bits below it.
    function automatic logic [FW-1:0] norm_frac(input logic [WIDTH-1:0] v, input logic [KW-1:0] k);
        logic [KW-1:0] sh;
        sh = KW'(WIDTH - 1) - k;
        return FW'(v << sh);
    endfunction

    // fsum carries FW fraction bits plus integer bits; fsum >= 1.0 selects 2^(k+1)*fsum.
    function automatic logic [2*WIDTH-1:0] antilog(input logic [KW:0] k, input logic [WIDTH:0] fsum);
        logic [WIDTH:0]       mant;
        logic [KW:0]          e;
        logic [3*WIDTH-2:0]   wide;
        if (fsum[WIDTH:WIDTH-1] == 2'b00) begin
            mant = fsum + ((WIDTH+1)'(1) << (WIDTH - 1));
            e    = k;
        end else begin
            mant = fsum;
            e    = k + (KW+1)'(1);
        end
        wide = (3*WIDTH-1)'(mant) << e;
        return (2*WIDTH)'(wide >> (WIDTH - 1));
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                      input logic neg, input logic zero);
        if (zero)
            return '0;
        return neg ? ((2*WIDTH)'(0) - mag) : mag;
    endfunction

    logic en;
    assign en      = ~valid_o | ready_i;
    assign ready_o = en;

    logic                 vld_p0, vld_p1, vld_p2;
    logic [2*WIDTH-1:0]   p_p2;

    logic [KW-1:0]        kx_p0, ky_p0;
    logic [FW-1:0]        fx_p0, fy_p0;
    logic                 zero_p0, neg_p0;
    logic [KW:0]          k_p1;
    logic [WIDTH:0]       fsum_p1;
    logic                 zero_p1, neg_p1;

    logic [WIDTH-1:0]     mag_x, mag_y;
    logic [WIDTH:0]       fsum_c;

    // Stage 1: magnitude, leading-one detection, normalisation
    assign mag_x = abs_val(x_i, signed_i);
    assign mag_y = abs_val(y_i, signed_i);

    // Stage 2: log addition
    always_comb begin
        fsum_c = {2'b00, fx_p0} + {2'b00, fy_p0};
`ifdef MITCHELL_ERR_COMP_EN
        if (fx_p0 != '0 && fy_p0 != '0)
            fsum_c = fsum_c + ((WIDTH+1)'(1) << (WIDTH - 5));
`endif
    end

    always_ff @(posedge clk_i) begin
        if (en) begin
            kx_p0   <= lead_one(mag_x);
            ky_p0   <= lead_one(mag_y);
            fx_p0   <= norm_frac(mag_x, lead_one(mag_x));
            fy_p0   <= norm_frac(mag_y, lead_one(mag_y));
            zero_p0 <= (x_i == '0) || (y_i == '0);
            neg_p0  <= signed_i & (x_i[WIDTH-1] ^ y_i[WIDTH-1]);

            k_p1    <= {1'b0, kx_p0} + {1'b0, ky_p0};
            fsum_p1 <= fsum_c;
            zero_p1 <= zero_p0;
            neg_p1  <= neg_p0;
        end
    end

    // Stage 3: antilog, sign and zero mux; p_o loads only real results so it
    // stays clean after reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            p_p2   <= '0;
        end else if (en) begin
            vld_p0 <= valid_i;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (vld_p1)
                p_p2 <= apply_sign(antilog(k_p1, fsum_p1), neg_p1, zero_p1);
        end
    end

    assign p_o     = p_p2;
    assign valid_o = vld_p2;

endmodule
